sblock_cfg_loader: RTL and testbench
====================================

Name: sblock_cfg_loader

Overview:
- Serial configuration controller for a column of NUM_SBLK switch blocks. Each switch block holds 18 latched routing-dot control bits (9 horizontal, then 9 vertical).
- Accepts a bitstream over a valid/ready handshake and assembles one 18-bit word per block.
- Drives a shared bits bus plus one-hot high-enable write strobes, with latch-safe setup/hold sequencing.
- Sits between the top-level config port and the switch block array.

Parameters:
NUM_SBLK, 4, number of switch blocks loaded per run (1..64)
CFG_W, 18, bits per block word (9 H + 9 V)
WR_PULSE, 2, cycles wr_en is held high per block (>=1)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
start_i  input  1  begin a load run; sampled only in IDLE
abort_i  input  1  synchronous abort; ends run at next edge
cfg_data_i  input  1  serial config bit, MSB of each word first
cfg_valid_i  input  1  cfg_data_i valid
cfg_ready_o  output  1  loader accepts a bit this cycle
bits_o  output  CFG_W  shared word to all switch blocks; [17:9]=H[8:0], [8:0]=V[8:0]
wr_en_o  output  NUM_SBLK  one-hot latch enable; bit k targets block k
busy_o  output  1  run in progress (state != IDLE)
done_o  output  1  one-cycle pulse when all blocks are written
err_o  output  1  sticky error flag; cleared by start_i or reset

Behaviour:
- Reset (async, immediate): state=IDLE, wr_en_o=0, bits_o=0, cfg_ready_o=0, busy_o=0, done_o=0, err_o=0, blk_idx=0, bit_cnt=0. Switch block latches keep prior contents.
- States: IDLE, SHIFT, SETUP, WRITE, HOLD, DONE.
- IDLE:
  - start_i=1 -> SHIFT; blk_idx=0, bit_cnt=0, err_o=0.
  - start_i while busy is ignored.
- SHIFT:
  - cfg_ready_o=1.
  - On valid&&ready: shreg = {shreg[CFG_W-2:0], cfg_data_i}; bit_cnt++.
  - On acceptance of bit CFG_W-1 -> SETUP. The first received bit lands in bits_o[17].
  - Valid gaps stall without penalty.
- SETUP (1 cycle): bits_o = shreg, registered; wr_en_o=0; cfg_ready_o=0.
- WRITE (WR_PULSE cycles): wr_en_o[blk_idx]=1, all other bits 0. bits_o stable.
- HOLD (1 cycle): wr_en_o=0, bits_o unchanged.
  - Then, if blk_idx==NUM_SBLK-1 -> DONE.
  - Otherwise blk_idx++, bit_cnt=0 -> SHIFT.
- DONE (1 cycle): done_o=1 -> IDLE.
- bits_o changes only on the SETUP entry edge. It never changes while any wr_en_o bit is high, nor in the cycle before or after.
- wr_en_o is at most one-hot in all states.
- cfg_ready_o is 0 outside SHIFT. Bits offered outside SHIFT are not consumed.
- abort_i:
  - Has priority over all transitions.
  - Next edge: state=IDLE, wr_en_o=0, no done_o.
  - Blocks already written keep their data. A block mid-WRITE may hold a partial update; software must rerun the load.
- start_i and abort_i in the same IDLE cycle: abort wins, stays IDLE.
- Counters are sized clog2(CFG_W) and clog2(NUM_SBLK), with a minimum of 1 bit. No wrap occurs past NUM_SBLK-1.

Optional Feature:
Macro SBLK_CFG_PARITY_EN.
- Defined:
  - Each word is followed by one even-parity bit, so SHIFT accepts CFG_W+1 bits.
  - Parity is computed over the 18 data bits plus the parity bit and must be 0.
  - On mismatch: err_o=1, no SETUP/WRITE for that block, state -> IDLE, no done_o.
- Not defined:
  - Exactly CFG_W bits per word; err_o is tied to 0.
  - No parity logic is synthesized.

Test Plan:
- Reset mid-WRITE (rst_n low while wr_en_o=4'b0100) -> wr_en_o=0 immediately (async), busy_o=0, state IDLE after release.
- Basic load, NUM_SBLK=4, WR_PULSE=2, words 18'h3FFFF, 18'h00000, 18'h2AAAA, 18'h15555, continuous valid:
  - Each word appears on bits_o one cycle before wr_en_o bit k goes high.
  - wr_en_o = 0001/0010/0100/1000, each high exactly 2 cycles.
  - Single done_o pulse.
  - Total 4*(18+1+2+1)+1 = 89 cycles from the first SHIFT cycle.
- Backpressure/gaps: deassert cfg_valid_i every other cycle while loading word 18'h24924 -> identical bits_o value, shift phase doubled, no dropped or duplicated bits.
- Latch-safety check: monitor asserts that bits_o is stable whenever any wr_en_o bit is high and for 1 cycle before and after, that wr_en_o is never more than one-hot, and that cfg_ready_o=0 outside SHIFT.
- Abort during SHIFT of block 2 (after 7 bits) -> IDLE next cycle, wr_en_o stays 0, no done_o. A new start_i reloads from block 0.
- With SBLK_CFG_PARITY_EN:
  - Word 18'h00001 with parity 1 -> written, err_o=0.
  - Same word with parity 0 -> err_o=1, no wr_en_o pulse, busy_o=0.
  - The next start_i clears err_o.

Source files
------------

// File: rtl/sblock_cfg_loader.sv
// sblock_cfg_loader: serial configuration loader for a column of switch blocks.
// Assembles one CFG_W-bit word per block from a valid/ready bitstream (MSB first),
// presents it on a shared bus and pulses a one-hot latch enable with one idle
// cycle of setup before and hold after each pulse.
// Optional build macro: SBLK_CFG_PARITY_EN (adds a trailing even-parity bit per word).
module sblock_cfg_loader #(
    parameter int unsigned NUM_SBLK = 4,
    parameter int unsigned CFG_W    = 18,
    parameter int unsigned WR_PULSE = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic                abort_i,
    input  logic                cfg_data_i,
    input  logic                cfg_valid_i,
    output logic                cfg_ready_o,
    output logic [CFG_W-1:0]    bits_o,
    output logic [NUM_SBLK-1:0] wr_en_o,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o
);

`ifdef SBLK_CFG_PARITY_EN
    localparam int unsigned WORD_BITS = CFG_W + 1;
`else
    localparam int unsigned WORD_BITS = CFG_W;
`endif
    localparam int unsigned CNT_W   = ($clog2(WORD_BITS) > 0) ? $clog2(WORD_BITS) : 1;
    localparam int unsigned BLK_W   = ($clog2(NUM_SBLK) > 0) ? $clog2(NUM_SBLK) : 1;
    localparam int unsigned PULSE_W = ($clog2(WR_PULSE) > 0) ? $clog2(WR_PULSE) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_SETUP,
        ST_WRITE,
        ST_HOLD,
        ST_DONE
    } state_e;

    state_e               state_q;
    logic [CFG_W-1:0]     shreg_q;
    logic [CFG_W-1:0]     shreg_d;
    logic [CNT_W-1:0]     bit_cnt_q;
    logic [CNT_W-1:0]     bit_cnt_d;
    logic [BLK_W-1:0]     blk_idx_q;
    logic [PULSE_W-1:0]   pulse_cnt_q;
    logic [CFG_W-1:0]     bits_q;
    logic [NUM_SBLK-1:0]  wr_en_q;
    logic                 ready_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 last_bit_c;
    logic                 last_blk_c;
    logic                 pulse_end_c;
`ifdef SBLK_CFG_PARITY_EN
    logic                 par_q;
    logic                 par_d;
    logic                 err_q;
`endif

    // Next shift-register value, counter increment and end-of-phase decodes
    always_comb begin
        shreg_d     = {shreg_q[CFG_W-2:0], cfg_data_i};
        last_bit_c  = (bit_cnt_q == CNT_W'(WORD_BITS - 1));
        bit_cnt_d   = last_bit_c ? '0 : bit_cnt_q + CNT_W'(1);
        last_blk_c  = (blk_idx_q == BLK_W'(NUM_SBLK - 1));
        pulse_end_c = (pulse_cnt_q == PULSE_W'(WR_PULSE - 1));
`ifdef SBLK_CFG_PARITY_EN
        par_d       = par_q ^ cfg_data_i;
`endif
    end

    // Loader FSM with registered outputs; abort overrides every transition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            shreg_q     <= '0;
            bit_cnt_q   <= '0;
            blk_idx_q   <= '0;
            pulse_cnt_q <= '0;
            bits_q      <= '0;
            wr_en_q     <= '0;
            ready_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
`ifdef SBLK_CFG_PARITY_EN
            par_q       <= 1'b0;
            err_q       <= 1'b0;
`endif
        end else if (abort_i) begin
            state_q <= ST_IDLE;
            wr_en_q <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        state_q   <= ST_SHIFT;
                        blk_idx_q <= '0;
                        bit_cnt_q <= '0;
                        ready_q   <= 1'b1;
                        busy_q    <= 1'b1;
`ifdef SBLK_CFG_PARITY_EN
                        par_q     <= 1'b0;
                        err_q     <= 1'b0;
`endif
                    end
                end

                ST_SHIFT: begin
                    if (cfg_valid_i) begin
                        bit_cnt_q <= bit_cnt_d;
`ifdef SBLK_CFG_PARITY_EN
                        par_q <= par_d;
                        if (!last_bit_c) begin
                            shreg_q <= shreg_d;
                        end else if (!par_d) begin
                            // parity bit closes the word; data is already in shreg
                            bits_q  <= shreg_q;
                            ready_q <= 1'b0;
                            state_q <= ST_SETUP;
                        end else begin
                            err_q   <= 1'b1;
                            ready_q <= 1'b0;
                            busy_q  <= 1'b0;
                            state_q <= ST_IDLE;
                        end
`else
                        shreg_q <= shreg_d;
                        if (last_bit_c) begin
                            bits_q  <= shreg_d;
                            ready_q <= 1'b0;
                            state_q <= ST_SETUP;
                        end
`endif
                    end
                end

                ST_SETUP: begin
                    wr_en_q     <= NUM_SBLK'(1) << blk_idx_q;
                    pulse_cnt_q <= '0;
                    state_q     <= ST_WRITE;
                end

                ST_WRITE: begin
                    if (pulse_end_c) begin
                        wr_en_q <= '0;
                        state_q <= ST_HOLD;
                    end else begin
                        pulse_cnt_q <= pulse_cnt_q + PULSE_W'(1);
                    end
                end

                ST_HOLD: begin
                    if (last_blk_c) begin
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        blk_idx_q <= blk_idx_q + BLK_W'(1);
                        bit_cnt_q <= '0;
                        ready_q   <= 1'b1;
                        state_q   <= ST_SHIFT;
`ifdef SBLK_CFG_PARITY_EN
                        par_q     <= 1'b0;
`endif
                    end
                end

                ST_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end

                default: begin
                    wr_en_q <= '0;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cfg_ready_o = ready_q;
    assign bits_o      = bits_q;
    assign wr_en_o     = wr_en_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
`ifdef SBLK_CFG_PARITY_EN
    assign err_o       = err_q;
`else
    assign err_o       = 1'b0;
`endif

endmodule

// File: tb/tb_sblock_cfg_loader.sv
// Bench for sblock_cfg_loader: cycle-level reference model driven by the
// loader's rules (bit counts, per-block phase offsets), latch scoreboard and
// latch-safety monitor, plus directed and randomized load runs.
module tb_sblock_cfg_loader;
    localparam int unsigned NUM_SBLK = 4;
    localparam int unsigned CFG_W    = 18;
    localparam int unsigned WR_PULSE = 2;
`ifdef SBLK_CFG_PARITY_EN
    localparam int unsigned WORD_BITS = CFG_W + 1;
    localparam bit          PAR_EN    = 1'b1;
    localparam int          BASIC_CYC = 93;
`else
    localparam int unsigned WORD_BITS = CFG_W;
    localparam bit          PAR_EN    = 1'b0;
    localparam int          BASIC_CYC = 89;
`endif

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic                abort;
    logic                cfg_data;
    logic                cfg_valid;
    logic                cfg_ready_o;
    logic [CFG_W-1:0]    bits_o;
    logic [NUM_SBLK-1:0] wr_en_o;
    logic                busy_o;
    logic                done_o;
    logic                err_o;

    sblock_cfg_loader #(.NUM_SBLK(NUM_SBLK), .CFG_W(CFG_W), .WR_PULSE(WR_PULSE)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort),
        .cfg_data_i(cfg_data), .cfg_valid_i(cfg_valid), .cfg_ready_o(cfg_ready_o),
        .bits_o(bits_o), .wr_en_o(wr_en_o), .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // m_post: -1 while collecting bits, 0 = setup cycle, 1..WR_PULSE = pulse, WR_PULSE+1 = hold
    bit               m_busy = 0;
    bit               m_done = 0;
    bit               m_err  = 0;
    bit               m_par  = 0;
    int               m_post = -1;
    int               m_cnt  = 0;
    int               m_blk  = 0;
    logic [CFG_W-1:0] m_word = '0;
    logic [CFG_W-1:0] m_bits = '0;
    bit               bitq[$];
    int               gap_mode = 0;
    bit               chk_en = 0;

    function automatic logic [NUM_SBLK-1:0] exp_wr();
        if (m_busy && m_post >= 1 && m_post <= int'(WR_PULSE)) return NUM_SBLK'(1) << m_blk;
        return '0;
    endfunction

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_busy = 0; m_done = 0; m_err = 0; m_par = 0;
            m_post = -1; m_cnt = 0; m_blk = 0; m_bits = '0; m_word = '0;
        end else if (abort) begin
            m_busy = 0; m_done = 0; m_post = -1;
        end else if (!m_busy) begin
            if (start) begin
                m_busy = 1; m_blk = 0; m_cnt = 0; m_post = -1; m_err = 0; m_par = 0;
            end
        end else if (m_done) begin
            m_done = 0; m_busy = 0;
        end else if (m_post < 0) begin
            if (cfg_valid) begin
                if (bitq.size() > 0) void'(bitq.pop_front());
                if (m_cnt < int'(CFG_W)) m_word = {m_word[CFG_W-2:0], cfg_data};
                m_par = m_par ^ cfg_data;
                m_cnt++;
                if (m_cnt == int'(WORD_BITS)) begin
                    if (PAR_EN && m_par) begin
                        m_err = 1; m_busy = 0;
                    end else begin
                        m_bits = m_word; m_post = 0;
                    end
                end
            end
        end else if (m_post < int'(WR_PULSE) + 1) begin
            m_post++;
        end else begin
            m_post = -1;
            if (m_blk == int'(NUM_SBLK) - 1) m_done = 1;
            else begin m_blk++; m_cnt = 0; m_par = 0; end
        end
    end

    // ---------------- bit feeder ----------------
    bit vtog = 0;
    initial begin
        cfg_valid = 1'b0;
        cfg_data  = 1'b0;
        forever begin
            @(negedge clk);
            vtog = ~vtog;
            cfg_valid = (bitq.size() > 0) && ((gap_mode == 0) ? 1'b1 :
                        (gap_mode == 1) ? vtog : 1'($urandom_range(0, 1)));
            cfg_data  = (bitq.size() > 0) ? bitq[0] : 1'($urandom_range(0, 1));
        end
    end

    // ---------------- compare, monitor, scoreboard ----------------
    logic [CFG_W-1:0]    lat [NUM_SBLK];
    int                  cnt_wr [NUM_SBLK];
    int                  cnt_busy = 0;
    int                  cnt_done = 0;
    int                  cnt_rdy  = 0;
    logic [CFG_W-1:0]    prev_bits = '0;
    logic [NUM_SBLK-1:0] prev_wr = '0;
    bit                  hist_ok = 0;

    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            hist_ok = 0;
        end else if (chk_en) begin
            check("ready", cfg_ready_o, m_busy && m_post < 0 && !m_done);
            check("bits", bits_o, m_bits);
            check("wr_en", wr_en_o, exp_wr());
            check("busy", busy_o, m_busy);
            check("done", done_o, m_done);
            check("err", err_o, m_err);
            if (hist_ok)
                check("bits_stable", (bits_o != prev_bits) && (wr_en_o != '0 || prev_wr != '0), 0);
            check("onehot", $countones(wr_en_o) <= 1, 1);
            check("ready_vs_wr", cfg_ready_o && (wr_en_o != '0), 0);
            prev_bits = bits_o; prev_wr = wr_en_o; hist_ok = 1;
            cnt_busy += int'(busy_o);
            cnt_done += int'(done_o);
            cnt_rdy  += int'(cfg_ready_o);
            for (int k = 0; k < int'(NUM_SBLK); k++)
                if (wr_en_o[k]) begin cnt_wr[k]++; lat[k] = bits_o; end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic push_word(input logic [CFG_W-1:0] w, input bit bad_par);
        for (int i = int'(CFG_W) - 1; i >= 0; i--) bitq.push_back(w[i]);
        if (PAR_EN) bitq.push_back((^w) ^ bad_par);
    endtask

    task automatic clr_stats();
        cnt_busy = 0; cnt_done = 0; cnt_rdy = 0;
        for (int k = 0; k < int'(NUM_SBLK); k++) cnt_wr[k] = 0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        clr_stats();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int c = 0;
        while (busy_o === 1'b1 && c < 3000) begin @(negedge clk); c++; end
        check({name, "_timeout"}, busy_o, 0);
    endtask

    logic [CFG_W-1:0] w [NUM_SBLK];
    logic [CFG_W-1:0] old_lat [NUM_SBLK];

    initial begin
        rst_n = 1'b0; start = 1'b0; abort = 1'b0;
        for (int k = 0; k < int'(NUM_SBLK); k++) begin lat[k] = '0; cnt_wr[k] = 0; end
        repeat (3) @(negedge clk);
        check("rst_ready", cfg_ready_o, 0);
        check("rst_bits", bits_o, 0);
        check("rst_wr", wr_en_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_err", err_o, 0);
        rst_n = 1'b1; chk_en = 1;
        @(negedge clk);

        // basic load, continuous valid
        gap_mode = 0;
        push_word(18'h3FFFF, 0); push_word(18'h00000, 0);
        push_word(18'h2AAAA, 0); push_word(18'h15555, 0);
        pulse_start();
        wait_idle("basic");
        check("basic_cycles", cnt_busy, BASIC_CYC);
        check("basic_done", cnt_done, 1);
        check("basic_rdy", cnt_rdy, 4 * WORD_BITS);
        for (int k = 0; k < int'(NUM_SBLK); k++) check("basic_pulse", cnt_wr[k], 2);
        check("basic_lat0", lat[0], 18'h3FFFF);
        check("basic_lat1", lat[1], 18'h00000);
        check("basic_lat2", lat[2], 18'h2AAAA);
        check("basic_lat3", lat[3], 18'h15555);

        // alternating valid gaps
        gap_mode = 1;
        push_word(18'h24924, 0);
        for (int k = 1; k < int'(NUM_SBLK); k++) push_word(CFG_W'($urandom), 0);
        pulse_start();
        wait_idle("gap");
        check("gap_lat0", lat[0], 18'h24924);
        check("gap_rdy", (cnt_rdy >= 4 * (2 * WORD_BITS - 1)) && (cnt_rdy <= 4 * 2 * WORD_BITS), 1);
        check("gap_done", cnt_done, 1);

        // start and abort together in IDLE: abort wins
        @(negedge clk);
        start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        check("start_abort_idle", busy_o, 0);

        // abort during block 2 after 7 bits
        gap_mode = 0;
        for (int k = 0; k < int'(NUM_SBLK); k++) old_lat[k] = lat[k];
        for (int k = 0; k < int'(NUM_SBLK); k++) begin w[k] = CFG_W'($urandom); push_word(w[k], 0); end
        pulse_start();
        begin
            int c = 0;
            while (!(m_blk == 2 && m_cnt == 7 && m_post < 0) && c < 500) begin @(negedge clk); c++; end
            check("abort_reach", c < 500, 1);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy_o, 0);
        check("abort_wr", wr_en_o, 0);
        repeat (3) @(negedge clk);
        check("abort_nodone", cnt_done, 0);
        check("abort_lat0", lat[0], w[0]);
        check("abort_lat1", lat[1], w[1]);
        check("abort_lat2", lat[2], old_lat[2]);
        check("abort_lat3", lat[3], old_lat[3]);
        bitq.delete();
        for (int k = 0; k < int'(NUM_SBLK); k++) begin w[k] = CFG_W'($urandom); push_word(w[k], 0); end
        pulse_start();
        wait_idle("reload");
        for (int k = 0; k < int'(NUM_SBLK); k++) check("reload_lat", lat[k], w[k]);
        check("reload_done", cnt_done, 1);

        // asynchronous reset while block 2 is being written
        for (int k = 0; k < int'(NUM_SBLK); k++) push_word(CFG_W'($urandom), 0);
        pulse_start();
        begin
            int c = 0;
            while (wr_en_o !== NUM_SBLK'(4) && c < 500) begin @(negedge clk); c++; end
            check("rstw_reach", wr_en_o, NUM_SBLK'(4));
        end
        #2 rst_n = 1'b0;
        #1;
        check("rstw_wr", wr_en_o, 0);
        check("rstw_busy", busy_o, 0);
        check("rstw_ready", cfg_ready_o, 0);
        bitq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rstw_idle", busy_o, 0);

`ifdef SBLK_CFG_PARITY_EN
        // good parity, then bad parity, then restart clears err
        gap_mode = 0;
        for (int k = 0; k < int'(NUM_SBLK); k++) push_word(18'h00001, 0);
        pulse_start();
        wait_idle("par_good");
        check("par_good_err", err_o, 0);
        check("par_good_lat0", lat[0], 18'h00001);
        push_word(18'h00001, 1);
        pulse_start();
        wait_idle("par_bad");
        check("par_bad_err", err_o, 1);
        check("par_bad_wr", cnt_wr[0], 0);
        check("par_bad_busy", busy_o, 0);
        for (int k = 0; k < int'(NUM_SBLK); k++) push_word(18'h00002, 0);
        pulse_start();
        check("par_clear_err", err_o, 0);
        wait_idle("par_clear");
`endif

        // randomized runs
        for (int r = 0; r < 16; r++) begin
            int first_bad = int'(NUM_SBLK);
            gap_mode = int'($urandom_range(0, 2));
            for (int k = 0; k < int'(NUM_SBLK); k++) begin
                bit bad;
                w[k] = CFG_W'($urandom);
                bad = PAR_EN && ($urandom_range(0, 5) == 0);
                if (bad && first_bad == int'(NUM_SBLK)) first_bad = k;
                push_word(w[k], bad);
            end
            pulse_start();
            repeat (2) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            wait_idle("rand");
            bitq.delete();
            for (int k = 0; k < first_bad; k++) check("rand_lat", lat[k], w[k]);
            check("rand_err", err_o, first_bad < int'(NUM_SBLK));
            check("rand_done", cnt_done, first_bad == int'(NUM_SBLK));
        end

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
